// File: rtl/math_pipe_arbiter.sv
// Round-robin arbiter feeding a 4-register pipeline that computes ((x / 3) + 1) * 5.
// Optional grant statistics are enabled with `define MATH_PIPE_ARB_STATS_EN.
module math_pipe_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Hold,
  input  logic             i_Req0_DV,
  input  logic [WIDTH-1:0] i_Req0_Data,
  output logic             o_Req0_Ready,
  input  logic             i_Req1_DV,
  input  logic [WIDTH-1:0] i_Req1_Data,
  output logic             o_Req1_Ready,
  output logic             o_Res_DV,
  output logic             o_Res_ID,
  output logic [WIDTH:0]   o_Res_Data,
  output logic             o_Busy,
  output logic [15:0]      o_Grant_Cnt0,
  output logic [15:0]      o_Grant_Cnt1
);

  logic             last_grant;
  logic             ready0;
  logic             ready1;
  logic             xfer;

  logic             s0_valid, s1_valid, s2_valid, s3_valid;
  logic             s0_id,    s1_id,    s2_id,    s3_id;
  logic [WIDTH-1:0] s0_data,  s1_data,  s2_data;
  logic [WIDTH:0]   s3_data;

  // Ready is gated by reset so nothing can be granted while the pipe is held clear.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (i_Rst_L && !i_Hold) begin
      if (i_Req0_DV && (!i_Req1_DV || last_grant))
        ready0 = 1'b1;
      else if (i_Req1_DV)
        ready1 = 1'b1;
    end
  end

  assign xfer         = ready0 | ready1;
  assign o_Req0_Ready = ready0;
  assign o_Req1_Ready = ready1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      last_grant <= 1'b1;
      s0_valid   <= 1'b0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      s0_id      <= 1'b0;
      s1_id      <= 1'b0;
      s2_id      <= 1'b0;
      s3_id      <= 1'b0;
      s0_data    <= '0;
      s1_data    <= '0;
      s2_data    <= '0;
      s3_data    <= '0;
    end else begin
      if (xfer)
        last_grant <= ready1;

      s0_valid <= xfer;
      s0_id    <= ready1;
      s0_data  <= ready1 ? i_Req1_Data : i_Req0_Data;

      s1_valid <= s0_valid;
      s1_id    <= s0_id;
      s1_data  <= s0_data / WIDTH'(3);

      // (2^W-1)/3 + 1 always fits in W bits, so S2 needs no extra bit.
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_data  <= s1_data + WIDTH'(1);

      s3_valid <= s2_valid;
      s3_id    <= s2_id;
      s3_data  <= {1'b0, s2_data} * (WIDTH+1)'(5);
    end
  end

  assign o_Res_DV   = s3_valid;
  assign o_Res_ID   = s3_id;
  assign o_Res_Data = s3_data;
  assign o_Busy     = s0_valid | s1_valid | s2_valid | s3_valid;

`ifdef MATH_PIPE_ARB_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;

  // Counters only write on a grant, and saturate rather than wrap.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (ready0 && grant_cnt0 != 16'hFFFF)
        grant_cnt0 <= grant_cnt0 + 16'd1;
      if (ready1 && grant_cnt1 != 16'hFFFF)
        grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end

  assign o_Grant_Cnt0 = grant_cnt0;
  assign o_Grant_Cnt1 = grant_cnt1;
`else
  assign o_Grant_Cnt0 = 16'h0000;
  assign o_Grant_Cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_math_pipe_arbiter.sv
// Self-checking bench for math_pipe_arbiter: directed cases then random traffic
// against a queue-based reference; define MATH_PIPE_ARB_STATS_EN to check counters.
module tb_math_pipe_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hold = 1'b0;
  logic         dv0 = 1'b0;
  logic         dv1 = 1'b0;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d1 = '0;
  logic         ready0, ready1, res_dv, res_id, busy;
  logic [W:0]   res_data;
  logic [15:0]  cnt0_out, cnt1_out;

  math_pipe_arbiter #(.WIDTH(W)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Hold       (hold),
    .i_Req0_DV    (dv0),
    .i_Req0_Data  (d0),
    .o_Req0_Ready (ready0),
    .i_Req1_DV    (dv1),
    .i_Req1_Data  (d1),
    .o_Req1_Ready (ready1),
    .o_Res_DV     (res_dv),
    .o_Res_ID     (res_id),
    .o_Res_Data   (res_data),
    .o_Busy       (busy),
    .o_Grant_Cnt0 (cnt0_out),
    .o_Grant_Cnt1 (cnt1_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int id;
    int data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last = 1;
  int   granted = -1;
  int   exp_cnt0 = 0;
  int   exp_cnt1 = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int f(input int x);
    return ((x / 3) + 1) * 5;
  endfunction

  // One clock: check Ready against the arbitration rules, then the result side.
  task automatic step();
    int winner;
    #1;
    if (hold)            winner = -1;
    else if (dv0 && dv1) winner = 1 - last;
    else if (dv0)        winner = 0;
    else if (dv1)        winner = 1;
    else                 winner = -1;
    check("ready0", 32'(ready0), 32'(winner == 0));
    check("ready1", 32'(ready1), 32'(winner == 1));
    granted = winner;
    @(posedge clk);
    cyc++;
    if (winner >= 0) begin
      q.push_back('{cyc + 3, winner, f(winner == 1 ? int'(d1) : int'(d0))});
      last = winner;
      if (winner == 0 && exp_cnt0 < 65535) exp_cnt0++;
      if (winner == 1 && exp_cnt1 < 65535) exp_cnt1++;
    end
    @(negedge clk);
    check("busy", 32'(busy), 32'(q.size() != 0));
    if (q.size() != 0 && q[0].due == cyc) begin
      check("res_dv", 32'(res_dv), 32'd1);
      check("res_id", 32'(res_id), 32'(q[0].id));
      check("res_data", 32'(res_data), 32'(q[0].data));
      void'(q.pop_front());
    end else begin
      check("res_dv_idle", 32'(res_dv), 32'd0);
    end
`ifdef MATH_PIPE_ARB_STATS_EN
    check("cnt0", 32'(cnt0_out), 32'(exp_cnt0));
    check("cnt1", 32'(cnt1_out), 32'(exp_cnt1));
`else
    check("cnt0_off", 32'(cnt0_out), 32'd0);
    check("cnt1_off", 32'(cnt1_out), 32'd0);
`endif
  endtask

  // Called at a negedge; pulses reset for one cycle with both requesters asking.
  task automatic pulse_reset();
    rst_n = 1'b0;
    dv0 = 1'b1;
    dv1 = 1'b1;
    #1;
    q.delete();
    last = 1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    check("rst_ready0", 32'(ready0), 32'd0);
    check("rst_ready1", 32'(ready1), 32'd0);
    check("rst_res_dv", 32'(res_dv), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_cnt0", 32'(cnt0_out), 32'd0);
    check("rst_cnt1", 32'(cnt1_out), 32'd0);
    dv0 = 1'b0;
    dv1 = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    pulse_reset();

    // single operation: 9 -> 20
    d0 = 8'd9; dv0 = 1'b1;
    step();
    dv0 = 1'b0;
    repeat (6) step();

    // maximum and minimum operands on requester 1
    d1 = 8'd255; dv1 = 1'b1;
    step();
    d1 = 8'd0;
    step();
    dv1 = 1'b0;
    repeat (5) step();

    // contention: alternating grants, back-to-back results
    d0 = 8'd3; d1 = 8'd6; dv0 = 1'b1; dv1 = 1'b1;
    repeat (8) step();
    dv0 = 1'b0; dv1 = 1'b0;
    repeat (5) step();

    // hold with results in flight, then release
    d0 = 8'd30; d1 = 8'd60; dv0 = 1'b1; dv1 = 1'b1;
    step();
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    repeat (2) step();
    dv0 = 1'b0; dv1 = 1'b0;
    repeat (5) step();

    // reset mid-flight discards everything; requester 0 wins next contention
    d0 = 8'd100; dv0 = 1'b1;
    repeat (3) step();
    pulse_reset();
    repeat (3) step();
    d0 = 8'd12; d1 = 8'd13; dv0 = 1'b1; dv1 = 1'b1;
    step();
    check("post_rst_winner", 32'(granted), 32'd0);
    dv0 = 1'b0; dv1 = 1'b0;
    repeat (5) step();

`ifdef MATH_PIPE_ARB_STATS_EN
    pulse_reset();
    dv0 = 1'b1; d0 = 8'd1;
    repeat (5) step();
    dv0 = 1'b0; dv1 = 1'b1; d1 = 8'd2;
    repeat (3) step();
    dv1 = 1'b0;
    repeat (5) step();
    check("stats_cnt0_5", 32'(cnt0_out), 32'd5);
    check("stats_cnt1_3", 32'(cnt1_out), 32'd3);
    force dut.grant_cnt0 = 16'hFFFE;
    #1;
    release dut.grant_cnt0;
    exp_cnt0 = 65534;
    dv0 = 1'b1;
    repeat (3) step();
    dv0 = 1'b0;
    repeat (5) step();
    check("stats_sat", 32'(cnt0_out), 32'hFFFF);
`endif

    // random traffic; a requester keeps DV and data until it is granted
    for (int i = 0; i < 400; i++) begin
      if (granted == 0 || !dv0) begin
        dv0 = ($urandom_range(0, 2) != 0);
        d0  = W'($urandom_range(0, 255));
      end
      if (granted == 1 || !dv1) begin
        dv1 = ($urandom_range(0, 2) != 0);
        d1  = W'($urandom_range(0, 255));
      end
      hold = ($urandom_range(0, 4) == 0);
      step();
    end
    dv0 = 1'b0; dv1 = 1'b0; hold = 1'b0;
    repeat (6) step();
    check("drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/math_pipe_arbiter.md
# math_pipe_arbiter

Shares one 3-stage pipelined compute unit, f(x) = ((x / 3) + 1) * 5, between two requesters. Round-robin arbitration uses a valid/ready handshake on the request side. Each result is tagged with the ID of the requester that issued it. The block sits between two producer blocks and the shared math datapath, so that each stage carries only one operation and timing closes at full clock rate.

## Interface
- WIDTH, 8, operand width in bits; result width is WIDTH+1
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Hold  in  1  when high, no new requests are granted; in-flight operations still drain
- i_Req0_DV  in  1  requester 0 operand valid
- i_Req0_Data  in  WIDTH  requester 0 operand
- o_Req0_Ready  out  1  requester 0 operand accepted this cycle
- i_Req1_DV  in  1  requester 1 operand valid
- i_Req1_Data  in  WIDTH  requester 1 operand
- o_Req1_Ready  out  1  requester 1 operand accepted this cycle
- o_Res_DV  out  1  result valid, single-cycle pulse per operation
- o_Res_ID  out  1  requester ID of the result
- o_Res_Data  out  WIDTH+1  result f(x)
- o_Busy  out  1  high while any pipeline stage holds a valid operation
- o_Grant_Cnt0  out  16  grants to requester 0 (see Configuration)
- o_Grant_Cnt1  out  16  grants to requester 1 (see Configuration)

## Operation
- **Transfer rule:** a transfer occurs on a rising edge where DV and Ready are both high.
  - Ready is combinational from the DVs, i_Hold and the priority pointer.
  - Ready never depends on any output of the requester other than its own DV.
- **Arbitration:**
  - At most one Ready is high per cycle.
  - i_Hold high: both Ready low.
  - Only one DV high: that requester gets Ready.
  - Both DV high: the requester not granted most recently wins.
- **Priority pointer r_Last_Grant:**
  - Updates on every transfer to the granted ID.
  - Reset value is 1, so requester 0 wins the first contention.
- **Requester rule:** a requester holds DV and Data stable until Ready. The arbiter does not check this rule.
- **Pipeline stages:** each stage is a register set of {valid, ID, data}.
  - S0: captures the granted operand and ID.
  - S1: S0 / 3, integer division truncated toward zero.
  - S2: S1 + 1.
  - S3: S2 * 5, at WIDTH+1 bits. S3 drives o_Res_*.
- **Result width:** the maximum result, ((2^WIDTH - 1) / 3 + 1) * 5, is less than 2^(WIDTH+1). No overflow and no truncation occur.
- **No stalls:** the pipeline never stalls, because the result side has no backpressure. Throughput is 1 operation per clock.
- **Empty stages:** a stage with valid=0 still clocks. o_Res_DV=0 whenever S3 is invalid; o_Res_Data is don't-care then.
- **o_Busy:** the OR of the S0..S3 valids.

## Timing
- **Reset values:** o_Res_DV=0, o_Res_ID=0, o_Res_Data=0, o_Busy=0, both grant counters=0, r_Last_Grant=1, all stage valids=0.
- **Outputs during reset:** while i_Rst_L is low, both Ready outputs are low.
- **Reset mid-operation:** asserting i_Rst_L clears all stage valids immediately. In-flight operations are discarded and produce no o_Res_DV.
- **Latency:** for a transfer on edge E, o_Res_DV is high for the cycle following edge E+3, i.e. after 4 register stages.
- **Ordering:** results emerge in grant order; IDs are never reordered.
- **Back-to-back traffic:** transfers on consecutive edges give o_Res_DV on consecutive cycles.
- **Simultaneous events:**
  - A transfer on the same edge that a result leaves S3 is legal and independent.
  - i_Hold rising on the same cycle a DV is high blocks that grant.

## Configuration
- **Macro:** MATH_PIPE_ARB_STATS_EN.
- **Defined:**
  - o_Grant_CntN increments by 1 on each transfer to requester N.
  - Counters saturate at 16'hFFFF.
  - Counters clear only on reset.
- **Undefined:** both counter ports remain on the interface, tied to 16'h0000, and no counter registers are built.

## Test plan
- **Single operation:** Req0 DV with Data=9 on one edge, Req1 idle -> o_Res_DV=1 after 4 register stages, o_Res_ID=0, o_Res_Data=20. o_Busy is high for the 4 cycles in between.
- **Maximum operand:** Req1 Data=255, Req0 idle -> o_Res_Data=430, o_Res_ID=1. Data=0 -> o_Res_Data=5.
- **Contention:** both DV held high for 8 cycles with Req0 Data=3 and Req1 Data=6 -> grants 0,1,0,1,... Results alternate 10 (ID 0) and 15 (ID 1) on consecutive cycles.
- **Hold:** i_Hold high for 3 cycles while both DV are high -> no Ready, and results already in flight still emerge. After release, requester 0 wins if it was not the last granted.
- **Reset mid-flight:** 3 operations issued, then i_Rst_L pulsed low for 1 cycle -> no o_Res_DV afterwards, o_Busy=0, and the next contention is won by requester 0.
- **Stats (macro defined):**
  - 5 grants to Req0 and 3 to Req1 -> counters read 5 and 3.
  - Counter preloaded near saturation via force to 16'hFFFE, then 3 grants -> counter holds at 16'hFFFF.
  - With the macro undefined, both counters read 0.
